// File: rtl/audio_stream_bridge.sv
// audio_stream_bridge: codec capture -> per-channel process (pass/avg/mute) -> frame FIFO -> codec playback.
// Optional build macro AUDIO_STREAM_BRIDGE_STATS_EN adds saturating drop_count / underrun_count outputs.
module audio_stream_bridge #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIDTH    = 24,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic                      read_ready,
  input  logic [CHANNELS*WIDTH-1:0] readdata,
  output logic                      read,
  input  logic                      write_ready,
  output logic [CHANNELS*WIDTH-1:0] writedata,
  output logic                      write,
  input  logic [1:0]                mode,
  output logic [$clog2(DEPTH):0]    fill_level,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      clear_flags
`ifdef AUDIO_STREAM_BRIDGE_STATS_EN
  ,
  output logic [15:0]               drop_count,
  output logic [15:0]               underrun_count
`endif
);

  localparam int unsigned FW   = CHANNELS * WIDTH;
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned FLW  = AW + 1;
  localparam int unsigned SW   = WIDTH + AVG_LOG2;
  localparam int unsigned HIST = 1 << AVG_LOG2;
  localparam int unsigned HW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  typedef enum logic {FILL, RUN} state_t;

  state_t                state, state_nxt;
  logic signed [WIDTH-1:0] hist [CHANNELS][HIST];
  logic signed [SW-1:0]  sum [CHANNELS];
  logic signed [SW-1:0]  sum_nxt [CHANNELS];
  logic signed [SW-1:0]  avg_full [CHANNELS];
  logic signed [WIDTH-1:0] smp [CHANNELS];
  logic [HW-1:0]         hidx;
  logic [FW-1:0]         proc_nxt;
  logic [FW-1:0]         proc_data;
  logic                  proc_valid;
  logic [FW-1:0]         mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  take_c, pop_c, push_ok_c, ovf_evt_c, uf_evt_c;
  logic [FW-1:0]         send_data_c;

  // Every offered frame is acknowledged immediately.
  assign read = read_ready;

  // Per-channel running sum update and mode-dependent sample selection.
  always_comb begin
    proc_nxt = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      smp[c]      = $signed(readdata[c*WIDTH +: WIDTH]);
      sum_nxt[c]  = sum[c] + SW'(smp[c]) - SW'(hist[c][hidx]);
      avg_full[c] = sum_nxt[c] >>> AVG_LOG2;
      case (mode)
        2'b01:   proc_nxt[c*WIDTH +: WIDTH] = avg_full[c][WIDTH-1:0];
        2'b10:   proc_nxt[c*WIDTH +: WIDTH] = '0;
        default: proc_nxt[c*WIDTH +: WIDTH] = smp[c];
      endcase
    end
  end

  // History ring and sums track every captured frame regardless of mode.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      hidx <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        sum[c] <= '0;
        for (int h = 0; h < HIST; h++) hist[c][h] <= '0;
      end
    end else if (read_ready) begin
      for (int c = 0; c < CHANNELS; c++) begin
        sum[c]        <= sum_nxt[c];
        hist[c][hidx] <= smp[c];
      end
      hidx <= (32'(hidx) == HIST - 1) ? '0 : hidx + HW'(1);
    end
  end

  // Processed-frame stage between capture and FIFO push.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      proc_valid <= 1'b0;
      proc_data  <= '0;
    end else begin
      proc_valid <= read_ready;
      if (read_ready) proc_data <= proc_nxt;
    end
  end

  // A full FIFO still accepts a push when the same edge pops.
  assign push_ok_c = proc_valid && ((fill_level != FLW'(DEPTH)) || pop_c);
  assign ovf_evt_c = proc_valid && (fill_level == FLW'(DEPTH)) && !pop_c;

  // Frame storage; contents need no reset.
  always_ff @(posedge CLOCK_50) begin
    if (push_ok_c) mem[wr_ptr] <= proc_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok_c, pop_c})
        2'b10:   fill_level <= fill_level + FLW'(1);
        2'b01:   fill_level <= fill_level - FLW'(1);
        default: fill_level <= fill_level;
      endcase
    end
  end

  // Playback state register.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= state_nxt;
  end

  // write_ready is only honoured while no write pulse is in flight.
  assign take_c = write_ready && !write;

  // Playback next-state: prefill to half depth, fall back on underrun.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (fill_level >= FLW'(DEPTH / 2)) state_nxt = RUN;
      RUN:     if (take_c && (fill_level == '0)) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Playback outputs: zero frames while filling or starved, FIFO head otherwise.
  always_comb begin
    pop_c       = 1'b0;
    uf_evt_c    = 1'b0;
    send_data_c = '0;
    if (take_c && (state == RUN)) begin
      if (fill_level != '0) begin
        pop_c       = 1'b1;
        send_data_c = mem[rd_ptr];
      end else begin
        uf_evt_c = 1'b1;
      end
    end
  end

  // Registered one-cycle write pulse with its frame.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      write     <= 1'b0;
      writedata <= '0;
    end else begin
      write <= take_c;
      if (take_c) writedata <= send_data_c;
    end
  end

  // Sticky flags; clear wins over a coincident event.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear_flags) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_evt_c) overflow  <= 1'b1;
      if (uf_evt_c)  underflow <= 1'b1;
    end
  end

`ifdef AUDIO_STREAM_BRIDGE_STATS_EN
  // Saturating event counters.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      drop_count     <= '0;
      underrun_count <= '0;
    end else if (clear_flags) begin
      drop_count     <= '0;
      underrun_count <= '0;
    end else begin
      if (ovf_evt_c && (drop_count != 16'hFFFF))    drop_count     <= drop_count + 16'd1;
      if (uf_evt_c && (underrun_count != 16'hFFFF)) underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_audio_stream_bridge.sv
// Self-checking bench for audio_stream_bridge; expected playback frames come from a scoreboard queue
// filled by a windowed-average reference model at capture time.
module tb_audio_stream_bridge;
  localparam int unsigned CH    = 2;
  localparam int unsigned W     = 24;
  localparam int unsigned FW    = CH * W;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          read_ready = 1'b0;
  logic [FW-1:0] readdata = '0;
  logic          read;
  logic          write_ready = 1'b0;
  logic [FW-1:0] writedata;
  logic          write;
  logic [1:0]    mode = 2'b00;
  logic [4:0]    fill_level;
  logic          overflow;
  logic          underflow;
  logic          clear_flags = 1'b0;
`ifdef AUDIO_STREAM_BRIDGE_STATS_EN
  logic [15:0]   drop_count;
  logic [15:0]   underrun_count;
`endif

  logic [FW-1:0] exp_q [$];
  int            total = 0;
  int            bad = 0;
  int            m_hist [CH][4];
  int            m_idx = 0;

  audio_stream_bridge #(.CHANNELS(CH), .WIDTH(W), .DEPTH(DEPTH), .AVG_LOG2(2)) dut (
    .CLOCK_50(clk), .reset(reset), .read_ready(read_ready), .readdata(readdata), .read(read),
    .write_ready(write_ready), .writedata(writedata), .write(write), .mode(mode),
    .fill_level(fill_level), .overflow(overflow), .underflow(underflow), .clear_flags(clear_flags)
`ifdef AUDIO_STREAM_BRIDGE_STATS_EN
    , .drop_count(drop_count), .underrun_count(underrun_count)
`endif
  );

  always #10 clk = ~clk;

  function automatic logic [FW-1:0] mkf(input int a, input int b);
    logic [31:0] ua, ub;
    ua = a;
    ub = b;
    return {ub[W-1:0], ua[W-1:0]};
  endfunction

  function automatic logic [FW-1:0] rndf();
    return mkf(int'($urandom), int'($urandom));
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++)
      for (int h = 0; h < 4; h++) m_hist[c][h] = 0;
    m_idx = 0;
  endtask

  // Reference: average of the last four samples, floored; history kept in every mode.
  task automatic model_frame(input logic [FW-1:0] f, input logic [1:0] md, output logic [FW-1:0] e);
    logic signed [W-1:0] sv;
    logic [31:0] rv;
    int s, tot, r;
    e = '0;
    for (int c = 0; c < CH; c++) begin
      sv = f[c*W +: W];
      s = sv;
      m_hist[c][m_idx] = s;
      tot = 0;
      for (int h = 0; h < 4; h++) tot += m_hist[c][h];
      case (md)
        2'b01:   r = tot >>> 2;
        2'b10:   r = 0;
        default: r = s;
      endcase
      rv = r;
      e[c*W +: W] = rv[W-1:0];
    end
    m_idx = (m_idx + 1) % 4;
  endtask

  // Drive one cycle of inputs, record the expected frame, advance past the next edge.
  task automatic step(input logic rr, input logic [FW-1:0] f, input logic [1:0] md,
                      input logic wr, input logic cf, input logic keep);
    logic [FW-1:0] e;
    read_ready = rr; readdata = f; mode = md; write_ready = wr; clear_flags = cf;
    if (rr) begin
      model_frame(f, md, e);
      if (keep) exp_q.push_back(e);
    end
    @(posedge clk); #1;
    read_ready = 1'b0; write_ready = 1'b0; clear_flags = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    read_ready = 1'b0; write_ready = 1'b0; clear_flags = 1'b0;
    reset = 1'b0;
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    total++; if (write !== 1'b0) begin bad++; $display("FAIL reset_write got=%0b exp=0", write); end
    total++; if (writedata !== '0) begin bad++; $display("FAIL reset_writedata got=%h exp=0", writedata); end
    total++; if (fill_level !== 5'd0) begin bad++; $display("FAIL reset_fill got=%0d exp=0", fill_level); end
    total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      bad++; $display("FAIL reset_flags got=%0b%0b exp=00", overflow, underflow); end
`ifdef AUDIO_STREAM_BRIDGE_STATS_EN
    total++; if (drop_count !== 16'd0 || underrun_count !== 16'd0) begin
      bad++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", drop_count, underrun_count); end
`endif
    read_ready = 1'b1; #1;
    total++; if (read !== 1'b1) begin bad++; $display("FAIL read_follow got=%0b exp=1", read); end
    read_ready = 1'b0; #1;
    total++; if (read !== 1'b0) begin bad++; $display("FAIL read_follow0 got=%0b exp=0", read); end
    apply_reset();
  endtask

  task automatic test_prefill();
    logic [FW-1:0] e;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, rndf(), 2'b00, (i % 2) == 0, 1'b0, 1'b1);
      if ((i % 2) == 0) begin
        total++; if (write !== 1'b1 || writedata !== '0) begin
          bad++; $display("FAIL prefill_zero i=%0d got=%0b/%h exp=1/0", i, write, writedata); end
      end
    end
    idle(1);
    total++; if (fill_level !== 5'd8) begin bad++; $display("FAIL prefill_level got=%0d exp=8", fill_level); end
    idle(1);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      total++; if (write !== 1'b1 || writedata !== e) begin
        bad++; $display("FAIL prefill_order k=%0d got=%0b/%h exp=1/%h", k, write, writedata, e); end
      idle(1);
      total++; if (write !== 1'b0) begin bad++; $display("FAIL write_pulse k=%0d got=%0b exp=0", k, write); end
    end
    total++; if (fill_level !== 5'd0) begin bad++; $display("FAIL prefill_drained got=%0d exp=0", fill_level); end
  endtask

  task automatic test_average();
    logic [FW-1:0] e;
    logic [W-1:0] ref0 [4];
    ref0[0] = 24'd1; ref0[1] = 24'd3; ref0[2] = 24'd6; ref0[3] = 24'd10;
    apply_reset();
    for (int i = 0; i < 8; i++) step(1'b1, mkf(4 * (i + 1), -3), 2'b01, 1'b0, 1'b0, 1'b1);
    idle(2);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      total++; if (writedata !== e) begin
        bad++; $display("FAIL avg_model k=%0d got=%h exp=%h", k, writedata, e); end
      if (k < 4) begin
        total++; if (writedata[W-1:0] !== ref0[k]) begin
          bad++; $display("FAIL avg_ch0 k=%0d got=%0d exp=%0d", k, writedata[W-1:0], ref0[k]); end
      end
      idle(1);
    end
    apply_reset();
    step(1'b1, mkf(-5, 0), 2'b01, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i < 8; i++) step(1'b1, mkf(i, i), 2'b01, 1'b0, 1'b0, 1'b1);
    idle(2);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      total++; if (writedata !== e) begin
        bad++; $display("FAIL avg_neg_model k=%0d got=%h exp=%h", k, writedata, e); end
      if (k == 0) begin
        total++; if (writedata[W-1:0] !== 24'hFFFFFE) begin
          bad++; $display("FAIL avg_neg_floor got=%h exp=fffffe", writedata[W-1:0]); end
      end
      idle(1);
    end
  endtask

  task automatic test_modes();
    logic [FW-1:0] e;
    logic [1:0] md [8];
    md[0] = 2'b00; md[1] = 2'b01; md[2] = 2'b10; md[3] = 2'b11;
    md[4] = 2'b10; md[5] = 2'b01; md[6] = 2'b00; md[7] = 2'b01;
    apply_reset();
    for (int i = 0; i < 8; i++) step(1'b1, rndf(), md[i], 1'b0, 1'b0, 1'b1);
    idle(2);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      total++; if (writedata !== e) begin
        bad++; $display("FAIL mode_mix k=%0d mode=%0d got=%h exp=%h", k, md[k], writedata, e); end
      idle(1);
    end
  endtask

  task automatic test_overflow();
    logic [FW-1:0] e;
    apply_reset();
    for (int i = 0; i < 17; i++) step(1'b1, rndf(), 2'b00, 1'b0, 1'b0, i < 16);
    idle(1);
    total++; if (fill_level !== 5'd16) begin bad++; $display("FAIL ovf_level got=%0d exp=16", fill_level); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
`ifdef AUDIO_STREAM_BRIDGE_STATS_EN
    total++; if (drop_count !== 16'd1) begin bad++; $display("FAIL ovf_count got=%0d exp=1", drop_count); end
`endif
    for (int k = 0; k < 16; k++) begin
      step(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      total++; if (writedata !== e) begin
        bad++; $display("FAIL ovf_drain k=%0d got=%h exp=%h", k, writedata, e); end
      idle(1);
    end
  endtask

  task automatic test_underflow();
    step(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0);
    total++; if (write !== 1'b1 || writedata !== '0) begin
      bad++; $display("FAIL uf_zero got=%0b/%h exp=1/0", write, writedata); end
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL uf_flag got=%0b exp=1", underflow); end
`ifdef AUDIO_STREAM_BRIDGE_STATS_EN
    total++; if (underrun_count !== 16'd1) begin bad++; $display("FAIL uf_count got=%0d exp=1", underrun_count); end
`endif
    step(1'b1, rndf(), 2'b00, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0);
    total++; if (write !== 1'b1 || writedata !== '0) begin
      bad++; $display("FAIL uf_back_to_fill got=%0b/%h exp=1/0", write, writedata); end
    total++; if (fill_level !== 5'd1) begin bad++; $display("FAIL uf_no_pop got=%0d exp=1", fill_level); end
  endtask

  task automatic test_clear();
    step(1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b0);
    total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      bad++; $display("FAIL clear_flags got=%0b%0b exp=00", overflow, underflow); end
`ifdef AUDIO_STREAM_BRIDGE_STATS_EN
    total++; if (drop_count !== 16'd0 || underrun_count !== 16'd0) begin
      bad++; $display("FAIL clear_stats got=%0d/%0d exp=0/0", drop_count, underrun_count); end
`endif
    apply_reset();
    for (int i = 0; i < 16; i++) step(1'b1, rndf(), 2'b00, 1'b0, 1'b0, 1'b1);
    step(1'b1, rndf(), 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b0);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clear_priority got=%0b exp=0", overflow); end
`ifdef AUDIO_STREAM_BRIDGE_STATS_EN
    total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL clear_priority_cnt got=%0d exp=0", drop_count); end
`endif
    step(1'b1, rndf(), 2'b00, 1'b0, 1'b0, 1'b0);
    idle(1);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_after_clear got=%0b exp=1", overflow); end
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] e;
    apply_reset();
    for (int i = 0; i < 16; i++) step(1'b1, rndf(), 2'b00, 1'b0, 1'b0, 1'b1);
    idle(1);
    total++; if (fill_level !== 5'd16) begin bad++; $display("FAIL simul_prefull got=%0d exp=16", fill_level); end
    step(1'b1, rndf(), 2'b00, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    total++; if (write !== 1'b1 || writedata !== e) begin
      bad++; $display("FAIL simul_head got=%0b/%h exp=1/%h", write, writedata, e); end
    total++; if (fill_level !== 5'd16) begin bad++; $display("FAIL simul_level got=%0d exp=16", fill_level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL simul_ovf got=%0b exp=0", overflow); end
    idle(1);
    for (int k = 0; k < 16; k++) begin
      step(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      total++; if (writedata !== e) begin
        bad++; $display("FAIL simul_drain k=%0d got=%h exp=%h", k, writedata, e); end
      idle(1);
    end
    total++; if (fill_level !== 5'd0) begin bad++; $display("FAIL simul_empty got=%0d exp=0", fill_level); end
  endtask

  task automatic test_reset_mid();
    logic [FW-1:0] e;
    apply_reset();
    for (int i = 0; i < 8; i++) step(1'b1, mkf(1000 + i, 2000 + i), 2'b00, 1'b0, 1'b0, 1'b1);
    idle(2);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      total++; if (writedata !== e) begin
        bad++; $display("FAIL mid_pre k=%0d got=%h exp=%h", k, writedata, e); end
      idle(1);
    end
    total++; if (fill_level !== 5'd5) begin bad++; $display("FAIL mid_level got=%0d exp=5", fill_level); end
    step(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    total++; if (write !== 1'b0 || writedata !== '0) begin
      bad++; $display("FAIL mid_async_out got=%0b/%h exp=0/0", write, writedata); end
    total++; if (fill_level !== 5'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      bad++; $display("FAIL mid_async_state got=%0d/%0b/%0b exp=0/0/0", fill_level, overflow, underflow); end
    exp_q.delete();
    model_reset();
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, mkf(16 * (i + 1), -(i + 1)), 2'b01, (i % 2) == 0, 1'b0, 1'b1);
      if ((i % 2) == 0) begin
        total++; if (write !== 1'b1 || writedata !== '0) begin
          bad++; $display("FAIL mid_refill i=%0d got=%0b/%h exp=1/0", i, write, writedata); end
      end
    end
    idle(2);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      total++; if (writedata !== e) begin
        bad++; $display("FAIL mid_post k=%0d got=%h exp=%h", k, writedata, e); end
      idle(1);
    end
  endtask

  initial begin
    test_reset();
    test_prefill();
    test_average();
    test_modes();
    test_overflow();
    test_underflow();
    test_clear();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
